vx_gbar_ctrl: RTL

- Global barrier controller: the slave side of the global-barrier bus, generalised to NUM_REQS requester channels, NUM_BARRIERS barriers and NUM_CORES cores.
- Arbitrates arrivals round-robin and tracks a per-barrier arrival mask.
- Broadcasts a one-cycle release response when all expected cores have arrived.
- Flags protocol errors: duplicate arrival, size mismatch, out-of-range core id.

---
 rtl/vx_gbar_ctrl_if.sv | 30 +++
 rtl/vx_gbar_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/vx_gbar_ctrl_if.sv
// Global-barrier bus: per-channel arrival requests toward the controller,
// plus the release, error and busy outputs it returns.
`timescale 1ns/1ps
interface vx_gbar_ctrl_if #(
   parameter int NUM_REQS     = 4,
   parameter int NUM_BARRIERS = 8,
   parameter int NB_WIDTH     = 3,
   parameter int NC_WIDTH     = 3
);
   logic [NUM_REQS-1:0]          req_valid;
   logic [NUM_REQS*NB_WIDTH-1:0] req_id;
   logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1;
   logic [NUM_REQS*NC_WIDTH-1:0] req_core_id;
   logic [NUM_REQS-1:0]          req_ready;
   logic                         rsp_valid;
   logic [NB_WIDTH-1:0]          rsp_id;
   logic                         err_valid;
   logic [1:0]                   err_code;
   logic [NUM_BARRIERS-1:0]      busy_mask;

   modport master (
      output req_valid, req_id, req_size_m1, req_core_id,
      input  req_ready, rsp_valid, rsp_id, err_valid, err_code, busy_mask
   );

   modport slave (
      input  req_valid, req_id, req_size_m1, req_core_id,
      output req_ready, rsp_valid, rsp_id, err_valid, err_code, busy_mask
   );
endinterface

// File: rtl/vx_gbar_ctrl.sv
// Global barrier controller: round-robin arrival arbiter, per-barrier arrival
// masks, one-cycle release broadcast and protocol error reporting.
`timescale 1ns/1ps
module vx_gbar_ctrl #(
   parameter int NUM_REQS     = 4,
   parameter int NUM_BARRIERS = 8,
   parameter int NUM_CORES    = 8,
   parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
   parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input logic           clk,
   input logic           reset,
   vx_gbar_ctrl_if.slave bus
);
   localparam int RP_WIDTH = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam logic [NC_WIDTH:0] CORES_LIMIT = (NC_WIDTH+1)'(NUM_CORES);
   localparam logic [NC_WIDTH:0] ONE_W       = (NC_WIDTH+1)'(1);

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_DUP  = 2'd1;
   localparam logic [1:0] ERR_SIZE = 2'd2;
   localparam logic [1:0] ERR_CORE = 2'd3;

   logic [NUM_CORES-1:0]    mask_q   [NUM_BARRIERS];
   logic [NUM_CORES-1:0]    mask_nxt [NUM_BARRIERS];
   logic [NC_WIDTH-1:0]     size_q   [NUM_BARRIERS];
   logic [NC_WIDTH-1:0]     size_nxt [NUM_BARRIERS];
   logic [RP_WIDTH-1:0]     ptr_q;
   logic [RP_WIDTH-1:0]     ptr_nxt;
   logic [RP_WIDTH-1:0]     rr_k;
   logic [RP_WIDTH-1:0]     gnt_idx;
   logic                    gnt_any;
   logic                    accept;

   logic [NB_WIDTH-1:0]     sel_id;
   logic [NC_WIDTH-1:0]     sel_size;
   logic [NC_WIDTH-1:0]     sel_core;
   logic                    core_bad;
   logic [NUM_CORES-1:0]    cur_mask;
   logic [NUM_CORES-1:0]    core_bit;
   logic [NUM_CORES-1:0]    new_mask;
   logic                    release_now;
   logic [1:0]              err_nxt;

   logic                    rsp_valid_q;
   logic [NB_WIDTH-1:0]     rsp_id_q;
   logic                    err_valid_q;
   logic [1:0]              err_code_q;
   logic [NUM_BARRIERS-1:0] busy_q;

   function automatic logic [NC_WIDTH:0] popcount(input logic [NUM_CORES-1:0] v);
      logic [NC_WIDTH:0] n;
      n = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         n = n + {{NC_WIDTH{1'b0}}, v[i]};
      end
      return n;
   endfunction

   // Round-robin search starting at the pointer; first valid channel wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      rr_k    = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
         rr_k = RP_WIDTH'((int'(ptr_q) + i) % NUM_REQS);
         if (!gnt_any && bus.req_valid[rr_k]) begin
            gnt_any = 1'b1;
            gnt_idx = rr_k;
         end
      end
   end

   // Grants are suppressed while reset is held so nothing is accepted in that cycle.
   assign accept = gnt_any && !reset;

   always_comb begin
      bus.req_ready = '0;
      if (accept) begin
         bus.req_ready[gnt_idx] = 1'b1;
      end
   end

   assign ptr_nxt  = (int'(gnt_idx) == NUM_REQS - 1) ? '0 : gnt_idx + 1'b1;
   assign sel_id   = bus.req_id[int'(gnt_idx)*NB_WIDTH +: NB_WIDTH];
   assign sel_size = bus.req_size_m1[int'(gnt_idx)*NC_WIDTH +: NC_WIDTH];
   assign sel_core = bus.req_core_id[int'(gnt_idx)*NC_WIDTH +: NC_WIDTH];
   assign core_bad = {1'b0, sel_core} >= CORES_LIMIT;
   assign cur_mask = mask_q[sel_id];

   always_comb begin
      core_bit = '0;
      if (!core_bad) begin
         core_bit[sel_core] = 1'b1;
      end
   end

   assign new_mask = cur_mask | core_bit;

   // The release compare is one bit wider than the size so size_m1 = NUM_CORES-1
   // cannot wrap to zero.
   always_comb begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         mask_nxt[b] = mask_q[b];
         size_nxt[b] = size_q[b];
      end
      release_now = 1'b0;
      err_nxt     = ERR_NONE;
      if (accept) begin
         if (core_bad) begin
            err_nxt = ERR_CORE;
         end else if (cur_mask[sel_core]) begin
            err_nxt = ERR_DUP;
         end else if ((cur_mask != '0) && (sel_size != size_q[sel_id])) begin
            err_nxt = ERR_SIZE;
         end else begin
            if (cur_mask == '0) begin
               size_nxt[sel_id] = sel_size;
            end
            if (popcount(new_mask) == ({1'b0, sel_size} + ONE_W)) begin
               release_now      = 1'b1;
               mask_nxt[sel_id] = '0;
            end else begin
               mask_nxt[sel_id] = new_mask;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            mask_q[b] <= '0;
            size_q[b] <= '0;
         end
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         busy_q      <= '0;
      end else begin
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            mask_q[b] <= mask_nxt[b];
            size_q[b] <= size_nxt[b];
            busy_q[b] <= |mask_nxt[b];
         end
         if (accept) begin
            ptr_q <= ptr_nxt;
         end
         rsp_valid_q <= release_now;
         if (release_now) begin
            rsp_id_q <= sel_id;
         end
         err_valid_q <= (err_nxt != ERR_NONE);
         err_code_q  <= err_nxt;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.err_valid = err_valid_q;
   assign bus.err_code  = err_code_q;
   assign bus.busy_mask = busy_q;

endmodule
